// File: rtl/uart_rx.sv
// Oversampling UART receiver for 8N1-style frames.
// Consumes the 16x b_tick strobe from the baud generator, centres on the start
// bit, samples each data bit at its middle and checks the stop bit. A received
// byte is presented with a one-clock rx_done pulse, alongside a framing-error flag.
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int SAMPLING  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int TW = $clog2(SAMPLING);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_HALF = TW'(SAMPLING / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLING - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                 state_reg, state_next;
  logic [TW-1:0]          tick_cnt_reg, tick_cnt_next;
  logic [BW-1:0]          bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic [DATA_BITS-1:0]   rx_data_reg, rx_data_next;
  logic                   frame_err_reg, frame_err_next;
  logic                   rx_done_reg, rx_done_next;
  logic                   rx_meta_reg, rxs_reg;

  // Two-flop synchroniser; both stages reset to the idle line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg <= 1'b1;
      rxs_reg     <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rxs_reg     <= rx_meta_reg;
    end
  end

  // State, counters, shifter and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      tick_cnt_reg  <= '0;
      bit_cnt_reg   <= '0;
      shift_reg     <= '0;
      rx_data_reg   <= '0;
      frame_err_reg <= 1'b0;
      rx_done_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tick_cnt_reg  <= tick_cnt_next;
      bit_cnt_reg   <= bit_cnt_next;
      shift_reg     <= shift_next;
      rx_data_reg   <= rx_data_next;
      frame_err_reg <= frame_err_next;
      rx_done_reg   <= rx_done_next;
    end
  end

  // Next-state and datapath decisions; every counter moves only on b_tick.
  always_comb begin
    state_next     = state_reg;
    tick_cnt_next  = tick_cnt_reg;
    bit_cnt_next   = bit_cnt_reg;
    shift_next     = shift_reg;
    rx_data_next   = rx_data_reg;
    frame_err_next = frame_err_reg;
    rx_done_next   = 1'b0;

    case (state_reg)
      S_IDLE: begin
        // A coincident b_tick is deliberately not counted here.
        if (!rxs_reg) begin
          state_next    = S_START;
          tick_cnt_next = '0;
        end
      end

      S_START: begin
        if (b_tick) begin
          if (tick_cnt_reg == TICK_HALF) begin
            if (!rxs_reg) begin
              state_next    = S_DATA;
              tick_cnt_next = '0;
              bit_cnt_next  = '0;
            end else begin
              // Line went back high before mid-start: treat as a glitch.
              state_next = S_IDLE;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (b_tick) begin
          if (tick_cnt_reg == TICK_LAST) begin
            // Right shift so the first (LSB) bit ends up at bit 0.
            shift_next    = {rxs_reg, shift_reg[DATA_BITS-1:1]};
            tick_cnt_next = '0;
            if (bit_cnt_reg == BIT_LAST) begin
              state_next = S_STOP;
            end else begin
              bit_cnt_next = bit_cnt_reg + 1'b1;
            end
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (b_tick) begin
          if (tick_cnt_reg == TICK_LAST) begin
            rx_data_next   = shift_reg;
            frame_err_next = ~rxs_reg;
            rx_done_next   = 1'b1;
            tick_cnt_next  = '0;
            state_next     = rxs_reg ? S_IDLE : S_BREAK;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
      end

      S_BREAK: begin
        // Hold off new frames until the line has returned high.
        if (rxs_reg) begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign rx_data   = rx_data_reg;
  assign rx_done   = rx_done_reg;
  assign frame_err = frame_err_reg;
  assign rx_busy   = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames, hand-written corner
// sequences (glitch, break, reset mid-frame, gated b_tick) and random frames
// checked against a frame-level reference decoder.
module tb_uart_rx;

  localparam int DB     = 8;
  localparam int SMP    = 16;
  localparam int TDIV   = 4;
  localparam int BITCLK = SMP * TDIV;

  logic          clk;
  logic          reset;
  logic          b_tick;
  logic          rx;
  logic [DB-1:0] rx_data;
  logic          rx_done;
  logic          frame_err;
  logic          rx_busy;

  int         tests    = 0;
  int         fails    = 0;
  int         done_cnt = 0;
  int         exp_cnt  = 0;
  logic       prev_done = 1'b0;
  logic       tick_en  = 1'b1;
  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         gap;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  vec_t vecs[4];

  uart_rx #(.DATA_BITS(DB), .SAMPLING(SMP)) dut (
    .clk      (clk),
    .reset    (reset),
    .b_tick   (b_tick),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .frame_err(frame_err),
    .rx_busy  (rx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Baud strobe: one clk every TDIV clocks, frozen while tick_en is low.
  initial begin
    int div;
    div    = 0;
    b_tick = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        if (div == TDIV - 1) begin
          b_tick = 1'b1;
          div    = 0;
        end else begin
          b_tick = 1'b0;
          div++;
        end
      end else begin
        b_tick = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference: bit 0 is the start bit, 1..8 data LSB first, 9 stop.
  function automatic logic [8:0] model(input logic [9:0] line);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = line[i + 1];
    return {~line[9], d};
  endfunction

  // Advance one clock; on every rx_done compare against the scoreboard.
  task automatic step();
    logic [8:0] e;
    @(negedge clk);
    if (rx_done) begin
      done_cnt++;
      check("done_not_double", {31'd0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_done: got rx_done with rx_data %0h, expected no rx_done", rx_data);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", {24'd0, rx_data}, {24'd0, e[7:0]});
        check("frame_err", {31'd0, frame_err}, {31'd0, e[8]});
        if (!e[8]) check("busy_at_done", {31'd0, rx_busy}, 32'd0);
        $display("[TB] frame rx_data=%02h frame_err=%0b", rx_data, frame_err);
      end
    end
    prev_done = rx_done;
  endtask

  task automatic drive(input logic v, input int n);
    rx = v;
    repeat (n) step();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic [8:0] exp,
                            input int stretch_bit, input int stretch);
    logic [9:0] line;
    line = {stop, d, 1'b0};
    exp_q.push_back(exp);
    exp_cnt++;
    for (int i = 0; i < 10; i++) begin
      if (stretch > 0 && i == stretch_bit + 1) begin
        drive(line[i], BITCLK / 2);
        tick_en = 1'b0;
        drive(line[i], stretch / 2);
        check("busy_while_gated", {31'd0, rx_busy}, 32'd1);
        drive(line[i], stretch - stretch / 2);
        tick_en = 1'b1;
        drive(line[i], BITCLK / 2);
      end else begin
        drive(line[i], BITCLK);
      end
    end
    check("done_count", done_cnt, exp_cnt);
  endtask

  initial begin
    logic [7:0] d;
    logic       s;
    int         gap;
    logic [7:0] abort_byte;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, gap: BITCLK, exp_data: 8'hA5, exp_err: 1'b0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, gap: 0,      exp_data: 8'h00, exp_err: 1'b0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, gap: BITCLK, exp_data: 8'hFF, exp_err: 1'b0};
    vecs[3] = '{data: 8'h6E, stop: 1'b1, gap: BITCLK, exp_data: 8'h6E, exp_err: 1'b0};

    // Reset state
    reset = 1'b1;
    rx    = 1'b1;
    step();
    check("reset_rx_data", {24'd0, rx_data}, 32'd0);
    check("reset_rx_done", {31'd0, rx_done}, 32'd0);
    check("reset_frame_err", {31'd0, frame_err}, 32'd0);
    check("reset_rx_busy", {31'd0, rx_busy}, 32'd0);
    step();
    reset = 1'b0;
    drive(1'b1, BITCLK);

    // Table-driven frames (entries 1 and 2 are back to back)
    foreach (vecs[k]) begin
      send_frame(vecs[k].data, vecs[k].stop, {vecs[k].exp_err, vecs[k].exp_data}, -1, 0);
      if (vecs[k].gap > 0) begin
        drive(1'b1, vecs[k].gap);
        check("busy_idle_after_frame", {31'd0, rx_busy}, 32'd0);
      end
    end

    // Start glitch: low for 4 ticks, then high
    drive(1'b0, 4 * TDIV);
    check("glitch_busy_high", {31'd0, rx_busy}, 32'd1);
    drive(1'b1, (SMP / 2) * TDIV);
    check("glitch_busy_low", {31'd0, rx_busy}, 32'd0);
    check("glitch_no_done", done_cnt, exp_cnt);
    drive(1'b1, BITCLK);

    // Stop bit low, line held low (break), then a valid frame
    send_frame(8'h3C, 1'b0, {1'b1, 8'h3C}, -1, 0);
    drive(1'b0, 40 * TDIV);
    check("break_no_done", done_cnt, exp_cnt);
    check("break_busy", {31'd0, rx_busy}, 32'd1);
    drive(1'b1, BITCLK);
    check("break_exit_idle", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h81, 1'b1, {1'b0, 8'h81}, -1, 0);
    drive(1'b1, BITCLK);

    // Reset after data bit 3; remaining bits are high so no start is seen
    abort_byte = 8'hF6;
    drive(1'b0, BITCLK);
    for (int i = 0; i < 4; i++) drive(abort_byte[i], BITCLK);
    reset = 1'b1;
    #1;
    check("midreset_rx_data", {24'd0, rx_data}, 32'd0);
    check("midreset_rx_done", {31'd0, rx_done}, 32'd0);
    check("midreset_frame_err", {31'd0, frame_err}, 32'd0);
    check("midreset_rx_busy", {31'd0, rx_busy}, 32'd0);
    rx = 1'b1;
    step();
    step();
    reset = 1'b0;
    drive(1'b1, 5 * BITCLK);
    check("midreset_no_done", done_cnt, exp_cnt);
    send_frame(8'h5A, 1'b1, {1'b0, 8'h5A}, -1, 0);
    drive(1'b1, BITCLK);

    // b_tick gated off for 100 clk in the middle of data bit 3
    send_frame(8'hC3, 1'b1, {1'b0, 8'hC3}, 3, 100);
    drive(1'b1, BITCLK);

    // Random frames against the reference decoder
    for (int n = 0; n < 16; n++) begin
      d   = 8'($urandom_range(0, 255));
      s   = ($urandom_range(0, 3) != 0);
      gap = $urandom_range(0, 80);
      if (!s && gap < 8) gap = 8;
      send_frame(d, s, model({s, d, 1'b0}), -1, 0);
      drive(1'b1, gap);
    end

    drive(1'b1, 200);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
